trap_ctrl: RTL and testbench

Machine-mode trap controller sitting directly downstream of the per-stage `exception_t` producers and the interrupt pending logic. It arbitrates synchronous exceptions and masked machine interrupts, and drives the trap-entry CSR writes (`mepc`/`mcause`/`mtval`/`mstatus`). It also handles pipeline flush and PC redirect to `mtvec` or `mepc` on `mret`. It turns the cause codes of `Exception_Pkg` into the architectural trap sequence.

---
 rtl/trap_ctrl.sv | 149 ++++++++++++++
 tb/tb_trap_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions, interrupts and mret, then runs COMMIT/REDIRECT.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets when mtvec.MODE == 1.
module trap_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int XLEN    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0][5:0]       exc_i,
    input  logic [NUM_SRC-1:0][XLEN-1:0]  epc_i,
    input  logic [NUM_SRC-1:0][XLEN-1:0]  tval_i,
    input  logic [3:0]                    irq_i,
    input  logic                          mstatus_mie_i,
    input  logic                          int_window_i,
    input  logic [XLEN-1:0]               int_pc_i,
    input  logic                          mret_i,
    input  logic [XLEN-1:0]               mtvec_i,
    input  logic [XLEN-1:0]               mepc_i,
    input  logic                          redirect_ready_i,
    output logic                          flush_o,
    output logic                          csr_trap_we_o,
    output logic                          csr_mret_we_o,
    output logic [XLEN-1:0]               mepc_o,
    output logic [XLEN-1:0]               mtval_o,
    output logic [XLEN-1:0]               mcause_o,
    output logic                          redirect_valid_o,
    output logic [XLEN-1:0]               redirect_pc_o,
    output logic                          busy_o
);

    typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;

    state_t            state, state_d;
    logic              is_mret_d;
    logic [XLEN-1:0]   mepc_d, mcause_d, mtval_d, pc_d;

    logic              exc_hit;
    logic [4:0]        exc_code;
    logic [XLEN-1:0]   exc_epc, exc_tval;
    logic              irq_take;
    logic [4:0]        irq_code;
    logic [XLEN-1:0]   base, irq_pc;

    function automatic logic [XLEN-1:0] pad_exc_code(input logic intr, input logic [4:0] code);
        return {intr, {(XLEN-6){1'b0}}, code};
    endfunction

    // Lowest index is the oldest stage, so scan downwards and let it overwrite.
    always_comb begin
        exc_hit  = 1'b0;
        exc_code = '0;
        exc_epc  = '0;
        exc_tval = '0;
        for (int i = NUM_SRC-1; i >= 0; i--) begin
            if (exc_i[i][5]) begin
                exc_hit  = 1'b1;
                exc_code = exc_i[i][4:0];
                exc_epc  = epc_i[i];
                exc_tval = tval_i[i];
            end
        end
    end

    // irq_i = {LCOF, MEI, MTI, MSI}; priority MEI > MSI > MTI > LCOF.
    always_comb begin
        irq_take = mstatus_mie_i & int_window_i & (|irq_i);
        if (irq_i[2])      irq_code = 5'd11;
        else if (irq_i[0]) irq_code = 5'd3;
        else if (irq_i[1]) irq_code = 5'd7;
        else               irq_code = 5'd13;
    end

    assign base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign irq_pc = (mtvec_i[1:0] == 2'b01)
                  ? base + {{(XLEN-7){1'b0}}, irq_code, 2'b00}
                  : base;
`else
    assign irq_pc = base;
`endif

    logic unused_bits;
    assign unused_bits = &{1'b0, mtvec_i[1:0], mepc_i[1:0]};

    always_comb begin
        state_d   = state;
        is_mret_d = csr_mret_we_o;
        mepc_d    = mepc_o;
        mcause_d  = mcause_o;
        mtval_d   = mtval_o;
        pc_d      = redirect_pc_o;
        case (state)
            IDLE: begin
                if (exc_hit) begin
                    state_d   = COMMIT;
                    is_mret_d = 1'b0;
                    mepc_d    = exc_epc;
                    mcause_d  = pad_exc_code(1'b0, exc_code);
                    mtval_d   = exc_tval;
                    pc_d      = base;
                end else if (irq_take) begin
                    state_d   = COMMIT;
                    is_mret_d = 1'b0;
                    mepc_d    = int_pc_i;
                    mcause_d  = pad_exc_code(1'b1, irq_code);
                    mtval_d   = '0;
                    pc_d      = irq_pc;
                end else if (mret_i) begin
                    // mret leaves the trap CSR values untouched; only the target moves.
                    state_d   = COMMIT;
                    is_mret_d = 1'b1;
                    pc_d      = {mepc_i[XLEN-1:2], 2'b00};
                end
            end
            COMMIT:   state_d = REDIRECT;
            REDIRECT: if (redirect_ready_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are flops loaded from the next-state decode, so none of them sees inputs combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            flush_o          <= 1'b0;
            csr_trap_we_o    <= 1'b0;
            csr_mret_we_o    <= 1'b0;
            redirect_valid_o <= 1'b0;
            busy_o           <= 1'b0;
            mepc_o           <= '0;
            mcause_o         <= '0;
            mtval_o          <= '0;
            redirect_pc_o    <= '0;
        end else begin
            state            <= state_d;
            flush_o          <= (state_d == COMMIT);
            csr_trap_we_o    <= (state_d == COMMIT) && !is_mret_d;
            csr_mret_we_o    <= (state_d == COMMIT) && is_mret_d;
            redirect_valid_o <= (state_d == REDIRECT);
            busy_o           <= (state_d != IDLE);
            mepc_o           <= mepc_d;
            mcause_o         <= mcause_d;
            mtval_o          <= mtval_d;
            redirect_pc_o    <= pc_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: scoreboard of expected trap records, one task per scenario.
// Build with +define+TRAP_VECTORED_EN to exercise the vectored target path.
module tb_trap_ctrl;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0][5:0]   exc;
    logic [3:0][31:0]  epc, tval;
    logic [3:0]        irq;
    logic              mie, window, mret, ready;
    logic [31:0]       int_pc, mtvec, mepc_in;
    logic              flush_o, csr_trap_we_o, csr_mret_we_o, redirect_valid_o, busy_o;
    logic [31:0]       mepc_o, mtval_o, mcause_o, redirect_pc_o;

    typedef struct {
        logic [31:0] mcause;
        logic [31:0] mepc;
        logic [31:0] mtval;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.NUM_SRC(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .exc_i(exc), .epc_i(epc), .tval_i(tval),
        .irq_i(irq), .mstatus_mie_i(mie), .int_window_i(window), .int_pc_i(int_pc),
        .mret_i(mret), .mtvec_i(mtvec), .mepc_i(mepc_in), .redirect_ready_i(ready),
        .flush_o(flush_o), .csr_trap_we_o(csr_trap_we_o), .csr_mret_we_o(csr_mret_we_o),
        .mepc_o(mepc_o), .mtval_o(mtval_o), .mcause_o(mcause_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        exc = '0; epc = '0; tval = '0; irq = '0;
        mie = 1'b0; window = 1'b0; mret = 1'b0; ready = 1'b1;
        int_pc = '0; mtvec = 32'h8000_0000; mepc_in = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc; cyc;
        rst = 1'b0;
        n_cmp++;
        if ({flush_o, csr_trap_we_o, csr_mret_we_o, redirect_valid_o, busy_o} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_strobes got %b want 00000",
                     {flush_o, csr_trap_we_o, csr_mret_we_o, redirect_valid_o, busy_o});
        end
        n_cmp++;
        if ({mepc_o, mcause_o, mtval_o, redirect_pc_o} !== 128'b0) begin
            n_err++;
            $display("FAIL reset_values got %h %h %h %h want 0", mepc_o, mcause_o, mtval_o, redirect_pc_o);
        end
    endtask

    task automatic test_exc_arb;
        exp_t e;
        sb.push_back('{32'd2, 32'h100, 32'h13, 32'h8000_0000});
        exc[2] = {1'b1, 5'd2}; epc[2] = 32'h100; tval[2] = 32'h13;
        cyc;
        exc = '0;
        e = sb.pop_front();
        n_cmp++;
        if ({flush_o, csr_trap_we_o, csr_mret_we_o, busy_o} !== 4'b1101) begin
            n_err++;
            $display("FAIL exc_commit_strobes got %b want 1101", {flush_o, csr_trap_we_o, csr_mret_we_o, busy_o});
        end
        n_cmp++;
        if ({mcause_o, mepc_o, mtval_o} !== {e.mcause, e.mepc, e.mtval}) begin
            n_err++;
            $display("FAIL exc_csr got %h %h %h want %h %h %h", mcause_o, mepc_o, mtval_o, e.mcause, e.mepc, e.mtval);
        end
        cyc;
        n_cmp++;
        if ({redirect_valid_o, flush_o, csr_trap_we_o} !== 3'b100 || redirect_pc_o !== e.pc) begin
            n_err++;
            $display("FAIL exc_redirect got v=%b f=%b pc=%h want v=1 f=0 pc=%h",
                     redirect_valid_o, flush_o, redirect_pc_o, e.pc);
        end
        cyc;
        n_cmp++;
        if ({busy_o, redirect_valid_o} !== 2'b00) begin
            n_err++;
            $display("FAIL exc_return_idle got busy=%b v=%b want 0 0", busy_o, redirect_valid_o);
        end
    endtask

    task automatic test_oldest;
        exp_t e;
        // Oldest of two simultaneous sources.
        sb.push_back('{32'd5, 32'h400, 32'hDEAD, 32'h8000_0000});
        exc[0] = {1'b1, 5'd5}; epc[0] = 32'h400; tval[0] = 32'hDEAD;
        exc[3] = {1'b1, 5'd3}; epc[3] = 32'h40C; tval[3] = 32'h1;
        cyc;
        exc = '0;
        e = sb.pop_front();
        n_cmp++;
        if ({mcause_o, mepc_o, mtval_o} !== {e.mcause, e.mepc, e.mtval}) begin
            n_err++;
            $display("FAIL oldest_csr got %h %h %h want %h %h %h", mcause_o, mepc_o, mtval_o, e.mcause, e.mepc, e.mtval);
        end
        cyc; cyc;
        // Exception alongside mret: exception wins and mret is dropped.
        sb.push_back('{32'd2, 32'h50, 32'h0, 32'h8000_0000});
        exc[3] = {1'b1, 5'd2}; epc[3] = 32'h50; mret = 1'b1; mepc_in = 32'h777;
        cyc;
        exc = '0; mret = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if ({csr_trap_we_o, csr_mret_we_o} !== 2'b10 || mcause_o !== e.mcause || mepc_o !== e.mepc) begin
            n_err++;
            $display("FAIL exc_over_mret got we=%b%b mcause=%h mepc=%h want 10 %h %h",
                     csr_trap_we_o, csr_mret_we_o, mcause_o, mepc_o, e.mcause, e.mepc);
        end
        cyc;
        n_cmp++;
        if (redirect_pc_o !== e.pc) begin
            n_err++;
            $display("FAIL exc_over_mret_pc got %h want %h", redirect_pc_o, e.pc);
        end
        cyc;
    endtask

    task automatic test_irq;
        logic [3:0]  pats  [4] = '{4'b0111, 4'b0011, 4'b1010, 4'b1000};
        logic [31:0] codes [4] = '{32'd11, 32'd3, 32'd7, 32'd13};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{32'h8000_0000 | codes[i], 32'h200 + 32'(i), 32'h0, 32'h8000_0000});
            irq = pats[i]; mie = 1'b1; window = 1'b1; int_pc = 32'h200 + 32'(i);
            cyc;
            irq = '0;
            e = sb.pop_front();
            n_cmp++;
            if ({csr_trap_we_o, mcause_o, mepc_o, mtval_o} !== {1'b1, e.mcause, e.mepc, e.mtval}) begin
                n_err++;
                $display("FAIL irq_csr[%0d] got we=%b %h %h %h want 1 %h %h %h", i,
                         csr_trap_we_o, mcause_o, mepc_o, mtval_o, e.mcause, e.mepc, e.mtval);
            end
            cyc;
            n_cmp++;
            if (redirect_valid_o !== 1'b1 || redirect_pc_o !== e.pc) begin
                n_err++;
                $display("FAIL irq_redirect[%0d] got v=%b pc=%h want 1 %h", i, redirect_valid_o, redirect_pc_o, e.pc);
            end
            cyc;
        end
        mie = 1'b0; window = 1'b0;
    endtask

    task automatic test_irq_masked;
        irq = 4'b1111; mie = 1'b0; window = 1'b1;
        cyc; cyc;
        n_cmp++;
        if ({busy_o, flush_o, csr_trap_we_o} !== 3'b000) begin
            n_err++;
            $display("FAIL irq_mie0 got busy=%b flush=%b we=%b want 000", busy_o, flush_o, csr_trap_we_o);
        end
        mie = 1'b1; window = 1'b0;
        cyc; cyc;
        n_cmp++;
        if ({busy_o, flush_o} !== 2'b00) begin
            n_err++;
            $display("FAIL irq_window0 got busy=%b flush=%b want 00", busy_o, flush_o);
        end
        irq = '0; mie = 1'b0;
    endtask

    task automatic test_vectored;
        exp_t        e;
        logic [31:0] vec_pc;
`ifdef TRAP_VECTORED_EN
        vec_pc = 32'h8000_001C;
`else
        vec_pc = 32'h8000_0000;
`endif
        mtvec = 32'h8000_0001;
        sb.push_back('{32'h8000_0007, 32'h300, 32'h0, vec_pc});
        irq = 4'b0010; mie = 1'b1; window = 1'b1; int_pc = 32'h300;
        cyc;
        irq = '0;
        e = sb.pop_front();
        n_cmp++;
        if (mcause_o !== e.mcause) begin
            n_err++;
            $display("FAIL vec_mti_cause got %h want %h", mcause_o, e.mcause);
        end
        cyc;
        n_cmp++;
        if (redirect_pc_o !== e.pc) begin
            n_err++;
            $display("FAIL vec_mti_pc got %h want %h", redirect_pc_o, e.pc);
        end
        cyc;
        sb.push_back('{32'd2, 32'h304, 32'h0, 32'h8000_0000});
        exc[1] = {1'b1, 5'd2}; epc[1] = 32'h304;
        cyc;
        exc = '0;
        e = sb.pop_front();
        cyc;
        n_cmp++;
        if (redirect_pc_o !== e.pc) begin
            n_err++;
            $display("FAIL vec_exc_pc got %h want %h", redirect_pc_o, e.pc);
        end
        cyc;
        mtvec = 32'h8000_0000; mie = 1'b0; window = 1'b0;
    endtask

    task automatic test_mret_backpressure;
        exp_t e;
        sb.push_back('{32'h0, 32'h0, 32'h0, 32'h3FC});
        mret = 1'b1; mepc_in = 32'h3FE; ready = 1'b0;
        cyc;
        mret = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if ({flush_o, csr_mret_we_o, csr_trap_we_o} !== 3'b110) begin
            n_err++;
            $display("FAIL mret_commit got f=%b mret_we=%b trap_we=%b want 110", flush_o, csr_mret_we_o, csr_trap_we_o);
        end
        for (int i = 0; i < 4; i++) begin
            cyc;
            if (i == 0) exc[1] = {1'b1, 5'd4};
            if (i == 3) begin
                exc = '0;
                ready = 1'b1;
            end
            n_cmp++;
            if ({redirect_valid_o, csr_mret_we_o, flush_o} !== 3'b100 || redirect_pc_o !== e.pc) begin
                n_err++;
                $display("FAIL mret_hold[%0d] got v=%b we=%b f=%b pc=%h want 100 %h", i,
                         redirect_valid_o, csr_mret_we_o, flush_o, redirect_pc_o, e.pc);
            end
        end
        cyc;
        n_cmp++;
        if ({busy_o, redirect_valid_o, flush_o} !== 3'b000) begin
            n_err++;
            $display("FAIL mret_exc_ignored got busy=%b v=%b f=%b want 000", busy_o, redirect_valid_o, flush_o);
        end
    endtask

    task automatic test_reset_mid_redirect;
        exp_t e;
        sb.push_back('{32'd1, 32'h600, 32'h44, 32'h8000_0000});
        exc[0] = {1'b1, 5'd1}; epc[0] = 32'h600; tval[0] = 32'h44; ready = 1'b0;
        cyc;
        exc = '0;
        e = sb.pop_front();
        cyc;
        n_cmp++;
        if (redirect_valid_o !== 1'b1 || mepc_o !== e.mepc) begin
            n_err++;
            $display("FAIL rst_pre got v=%b mepc=%h want 1 %h", redirect_valid_o, mepc_o, e.mepc);
        end
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        n_cmp++;
        if ({flush_o, csr_trap_we_o, csr_mret_we_o, redirect_valid_o, busy_o,
             mepc_o, mcause_o, mtval_o, redirect_pc_o} !== 133'b0) begin
            n_err++;
            $display("FAIL rst_mid got v=%b busy=%b mepc=%h mcause=%h pc=%h want all 0",
                     redirect_valid_o, busy_o, mepc_o, mcause_o, redirect_pc_o);
        end
        ready = 1'b1;
        cyc;
        n_cmp++;
        if ({busy_o, redirect_valid_o} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_idle got busy=%b v=%b want 00", busy_o, redirect_valid_o);
        end
    endtask

    task automatic test_back_to_back;
        exc[1] = {1'b1, 5'd6}; epc[1] = 32'h800;
        for (int i = 0; i < 7; i++) begin
            cyc;
            if (i == 6) exc = '0;
            n_cmp++;
            if ({flush_o, redirect_valid_o} !== {(i % 3) == 0, (i % 3) == 1}) begin
                n_err++;
                $display("FAIL b2b[%0d] got f=%b v=%b want f=%b v=%b", i, flush_o, redirect_valid_o,
                         (i % 3) == 0, (i % 3) == 1);
            end
        end
        cyc; cyc; cyc;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_exc_arb();
        test_oldest();
        test_irq();
        test_irq_masked();
        test_vectored();
        test_mret_backpressure();
        test_reset_mid_redirect();
        test_back_to_back();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
